// File: rtl/ysyx_20020207_axi_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter placed in front of the core's
// address-decoding crossbar. The IFU (read only) and the LSU (read and
// write) share one downstream port with a single transaction in flight.
// A round-robin bit picks the winner when both masters request at once.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no grant, every handshake/valid output held at 0
// IFU_RD | IFU read channel (ar/r) wired through to the downstream port
// LSU_RD | LSU read channel (ar/r) wired through to the downstream port
// LSU_WR | LSU write channels (aw/w/b) wired through to the downstream port
module ysyx_20020207_axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,

   input  logic [ADDR_W-1:0]     ifu_araddr,
   input  logic                  ifu_arvalid,
   output logic                  ifu_arready,
   output logic [DATA_W-1:0]     ifu_rdata,
   output logic [1:0]            ifu_rresp,
   output logic                  ifu_rvalid,
   input  logic                  ifu_rready,

   input  logic [ADDR_W-1:0]     lsu_araddr,
   input  logic                  lsu_arvalid,
   output logic                  lsu_arready,
   output logic [DATA_W-1:0]     lsu_rdata,
   output logic [1:0]            lsu_rresp,
   output logic                  lsu_rvalid,
   input  logic                  lsu_rready,

   input  logic [ADDR_W-1:0]     lsu_awaddr,
   input  logic                  lsu_awvalid,
   output logic                  lsu_awready,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wstrb,
   input  logic                  lsu_wvalid,
   output logic                  lsu_wready,
   output logic [1:0]            lsu_bresp,
   output logic                  lsu_bvalid,
   input  logic                  lsu_bready,

   output logic [ADDR_W-1:0]     m_araddr,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic [ADDR_W-1:0]     m_awaddr,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,

   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFU_RD = 2'd1,
      LSU_RD = 2'd2,
      LSU_WR = 2'd3
   } state_t;

   state_t state;
   logic   last_lsu;

   logic   ifu_req;
   logic   lsu_req;
   logic   grant_lsu;
   logic   grant_ifu;
   logic   rd_done;
   logic   wr_done;

   // Request decode and round-robin pick; LSU wins a tie unless it won last time.
   always_comb begin
      ifu_req   = ifu_arvalid;
      lsu_req   = lsu_arvalid | lsu_awvalid;
      grant_lsu = lsu_req & (~ifu_req | ~last_lsu);
      grant_ifu = ifu_req & ~grant_lsu;
      rd_done   = m_rvalid & m_rready;
      wr_done   = m_bvalid & m_bready;
   end

   // Grant FSM: pick a master in IDLE, hold the grant until its response handshake.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         last_lsu <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_lsu) begin
                  // a simultaneous write and read from the LSU goes to the write first
                  state    <= lsu_awvalid ? LSU_WR : LSU_RD;
                  last_lsu <= 1'b1;
               end else if (grant_ifu) begin
                  state    <= IFU_RD;
                  last_lsu <= 1'b0;
               end
            end
            IFU_RD, LSU_RD: begin
               if (rd_done) state <= IDLE;
            end
            LSU_WR: begin
               if (wr_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Channel routing: only the granted master's channels pass, everything else is 0.
   always_comb begin
      m_araddr    = '0;
      m_arvalid   = 1'b0;
      m_rready    = 1'b0;
      m_awaddr    = '0;
      m_awvalid   = 1'b0;
      m_wdata     = '0;
      m_wstrb     = '0;
      m_wvalid    = 1'b0;
      m_bready    = 1'b0;

      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = 2'b00;
      ifu_rvalid  = 1'b0;

      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = 2'b00;
      lsu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = 2'b00;
      lsu_bvalid  = 1'b0;

      case (state)
         IFU_RD: begin
            m_araddr    = ifu_araddr;
            m_arvalid   = ifu_arvalid;
            m_rready    = ifu_rready;
            ifu_arready = m_arready;
            ifu_rdata   = m_rdata;
            ifu_rresp   = m_rresp;
            ifu_rvalid  = m_rvalid;
         end
         LSU_RD: begin
            m_araddr    = lsu_araddr;
            m_arvalid   = lsu_arvalid;
            m_rready    = lsu_rready;
            lsu_arready = m_arready;
            lsu_rdata   = m_rdata;
            lsu_rresp   = m_rresp;
            lsu_rvalid  = m_rvalid;
         end
         LSU_WR: begin
            // aw and w are independent; either may handshake first
            m_awaddr    = lsu_awaddr;
            m_awvalid   = lsu_awvalid;
            m_wdata     = lsu_wdata;
            m_wstrb     = lsu_wstrb;
            m_wvalid    = lsu_wvalid;
            m_bready    = lsu_bready;
            lsu_awready = m_awready;
            lsu_wready  = m_wready;
            lsu_bresp   = m_bresp;
            lsu_bvalid  = m_bvalid;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ysyx_20020207_axi_arbiter.sv
// Directed and randomized bench for the two-master AXI4-Lite arbiter.
// The bench plays both masters and the downstream slave; a small
// round-robin reference decides which master should own each grant.
module tb_ysyx_20020207_axi_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;

   logic [31:0] ifu_araddr = '0;
   logic        ifu_arvalid = 1'b0;
   logic        ifu_arready;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rvalid;
   logic        ifu_rready = 1'b0;

   logic [31:0] lsu_araddr = '0;
   logic        lsu_arvalid = 1'b0;
   logic        lsu_arready;
   logic [31:0] lsu_rdata;
   logic [1:0]  lsu_rresp;
   logic        lsu_rvalid;
   logic        lsu_rready = 1'b0;
   logic [31:0] lsu_awaddr = '0;
   logic        lsu_awvalid = 1'b0;
   logic        lsu_awready;
   logic [31:0] lsu_wdata = '0;
   logic [3:0]  lsu_wstrb = '0;
   logic        lsu_wvalid = 1'b0;
   logic        lsu_wready;
   logic [1:0]  lsu_bresp;
   logic        lsu_bvalid;
   logic        lsu_bready = 1'b0;

   logic [31:0] m_araddr;
   logic        m_arvalid;
   logic        m_arready = 1'b0;
   logic [31:0] m_rdata = '0;
   logic [1:0]  m_rresp = '0;
   logic        m_rvalid = 1'b0;
   logic        m_rready;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready = 1'b0;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready = 1'b0;
   logic [1:0]  m_bresp = '0;
   logic        m_bvalid = 1'b0;
   logic        m_bready;
   logic        busy;

   ysyx_20020207_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .busy(busy)
   );

   always #5 clock = ~clock;

   logic any_out;
   assign any_out = |{ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
                      lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
                      lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
                      m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
                      m_wdata, m_wstrb, m_wvalid, m_bready, busy};

   int n_assert = 0;
   int n_fail   = 0;

   // per-cycle event counters observed mid-cycle
   int busy_cnt = 0, bvalid_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0;
   always @(negedge clock) begin
      if (busy) busy_cnt++;
      if (lsu_bvalid) bvalid_cnt++;
      if (m_awvalid && m_awready) aw_hs_cnt++;
      if (m_wvalid && m_wready) w_hs_cnt++;
   end

   // reference: outstanding requests and the round-robin memory
   bit          ref_last_lsu = 1'b0;
   bit          pend_ifu = 0, pend_lr = 0, pend_lw = 0;
   logic [31:0] ifu_addr_q, lsu_raddr_q, lsu_waddr_q, lsu_wdata_q;
   logic [3:0]  lsu_wstrb_q;

   bit          cfg_rand = 0;
   int          cfg_lat = 1, cfg_rhold = 0, cfg_wgap = 0;
   logic [31:0] cfg_rdata = '0;
   logic [1:0]  cfg_resp = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Who should own the next grant: 0 none, 1 IFU read, 2 LSU read, 3 LSU write.
   function automatic int model_pick();
      bit lsu_any;
      lsu_any = pend_lr | pend_lw;
      if (!pend_ifu && !lsu_any) return 0;
      if (lsu_any && (!pend_ifu || !ref_last_lsu)) begin
         ref_last_lsu = 1'b1;
         return pend_lw ? 3 : 2;
      end
      ref_last_lsu = 1'b0;
      return 1;
   endfunction

   task automatic req_ifu(input logic [31:0] a);
      ifu_araddr = a; ifu_arvalid = 1'b1; ifu_addr_q = a; pend_ifu = 1;
   endtask

   task automatic req_lsu_rd(input logic [31:0] a);
      lsu_araddr = a; lsu_arvalid = 1'b1; lsu_raddr_q = a; pend_lr = 1;
   endtask

   task automatic req_lsu_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      lsu_awaddr = a; lsu_awvalid = 1'b1; lsu_waddr_q = a;
      lsu_wdata_q = d; lsu_wstrb_q = s; pend_lw = 1;
   endtask

   // Entered 1 time unit after the edge that opened the grant; returns in the following IDLE cycle.
   task automatic read_txn(input bit lsu, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [1:0] resp, input int lat, input int rhold);
      #1;
      check("rd_busy", busy, 1);
      check("rd_m_arvalid", m_arvalid, 1);
      check("rd_m_araddr", m_araddr, addr);
      check("rd_m_awvalid", m_awvalid, 0);
      if (lsu) check("rd_ifu_blocked", {ifu_arready, ifu_rvalid}, 0);
      else     check("rd_lsu_blocked", {lsu_arready, lsu_awready, lsu_wready, lsu_rvalid, lsu_bvalid}, 0);
      m_arready = 1'b1;
      #1;
      check("rd_arready_granted", lsu ? lsu_arready : ifu_arready, 1);
      check("rd_arready_other", lsu ? ifu_arready : lsu_arready, 0);
      tick;
      m_arready = 1'b0;
      if (lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
      for (int i = 1; i < lat; i++) begin
         #1;
         check("rd_wait_rvalid", lsu ? lsu_rvalid : ifu_rvalid, 0);
         tick;
      end
      m_rvalid = 1'b1; m_rdata = rdata; m_rresp = resp;
      if (lsu) lsu_rready = (rhold == 0); else ifu_rready = (rhold == 0);
      #1;
      check("rd_rvalid", lsu ? lsu_rvalid : ifu_rvalid, 1);
      check("rd_rdata", lsu ? lsu_rdata : ifu_rdata, rdata);
      check("rd_rresp", lsu ? lsu_rresp : ifu_rresp, resp);
      check("rd_other_quiet", lsu ? {ifu_rvalid, ifu_rdata} : {lsu_rvalid, lsu_rdata}, 0);
      for (int h = 0; h < rhold; h++) begin
         check("hold_m_rready", m_rready, 0);
         check("hold_busy", busy, 1);
         check("hold_m_araddr", m_araddr, addr);
         tick;
         #1;
      end
      if (lsu) lsu_rready = 1'b1; else ifu_rready = 1'b1;
      #1;
      check("rd_m_rready", m_rready, 1);
      tick;
      m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
      lsu_rready = 1'b0; ifu_rready = 1'b0;
      #1;
      check("rd_end_idle", busy, 0);
      check("rd_end_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
   endtask

   // wgap: -1 when W was already valid before the grant, else cycles between AW and W handshakes.
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int wgap, input int lat, input logic [1:0] resp);
      bit w_now;
      if (wgap == 0) begin lsu_wvalid = 1'b1; lsu_wdata = data; lsu_wstrb = strb; end
      #1;
      w_now = lsu_wvalid;
      check("wr_busy", busy, 1);
      check("wr_m_awvalid", m_awvalid, 1);
      check("wr_m_awaddr", m_awaddr, addr);
      check("wr_m_arvalid", m_arvalid, 0);
      check("wr_m_wvalid", m_wvalid, w_now);
      if (w_now) check("wr_m_wdata", {m_wstrb, m_wdata}, {strb, data});
      m_awready = 1'b1; m_wready = 1'b1;
      #1;
      check("wr_awready", {lsu_awready, lsu_wready}, 2'b11);
      check("wr_ifu_blocked", {ifu_arready, ifu_rvalid, lsu_arready}, 0);
      tick;
      lsu_awvalid = 1'b0; m_awready = 1'b0;
      if (w_now) lsu_wvalid = 1'b0;
      else begin
         for (int i = 1; i < wgap; i++) tick;
         lsu_wvalid = 1'b1; lsu_wdata = data; lsu_wstrb = strb;
         #1;
         check("wr_late_w", {m_wvalid, m_wstrb, m_wdata}, {1'b1, strb, data});
         tick;
         lsu_wvalid = 1'b0;
      end
      for (int i = 1; i < lat; i++) begin
         #1;
         check("wr_wait_bvalid", lsu_bvalid, 0);
         tick;
      end
      m_bvalid = 1'b1; m_bresp = resp; lsu_bready = 1'b1;
      #1;
      check("wr_bvalid", {lsu_bvalid, lsu_bresp, m_bready}, {1'b1, resp, 1'b1});
      tick;
      m_bvalid = 1'b0; m_bresp = '0; lsu_bready = 1'b0; m_wready = 1'b0;
      #1;
      check("wr_end_idle", {busy, lsu_bvalid}, 0);
   endtask

   // Drain every pending request in the order the reference dictates.
   task automatic serve_all();
      int k;
      int guard;
      guard = 0;
      while ((pend_ifu || pend_lr || pend_lw) && guard < 6) begin
         guard++;
         tick;
         if (cfg_rand) begin
            cfg_lat   = $urandom_range(1, 3);
            cfg_rhold = $urandom_range(0, 2);
            cfg_rdata = $urandom;
            cfg_resp  = 2'($urandom_range(0, 3));
            cfg_wgap  = 2 * $urandom_range(0, 1);
         end
         k = model_pick();
         case (k)
            1: begin read_txn(0, ifu_addr_q, cfg_rdata, cfg_resp, cfg_lat, cfg_rhold); pend_ifu = 0; end
            2: begin read_txn(1, lsu_raddr_q, cfg_rdata, cfg_resp, cfg_lat, cfg_rhold); pend_lr = 0; end
            3: begin write_txn(lsu_waddr_q, lsu_wdata_q, lsu_wstrb_q, cfg_wgap, cfg_lat, cfg_resp); pend_lw = 0; end
            default: ;
         endcase
      end
      check("serve_drained", {pend_ifu, pend_lr, pend_lw}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int b0, bv0, aw0, w0, k;
      logic [31:0] a;

      // reset
      #2 reset_n = 1'b0;
      #1;
      check("reset_outputs", any_out, 0);
      tick; tick;
      reset_n = 1'b1;
      #1;
      check("reset_release_idle", any_out, 0);

      // IFU alone, 3-cycle slave latency
      req_ifu(32'h3000_0000);
      b0 = busy_cnt;
      tick;
      k = model_pick();
      check("ifu_alone_pick", k, 1);
      read_txn(0, 32'h3000_0000, 32'hDEAD_BEEF, 2'b00, 3, 0);
      pend_ifu = 0;
      check("ifu_alone_busy_cycles", busy_cnt - b0, 4);

      // simultaneous reads twice: LSU first both times
      cfg_rand = 0; cfg_lat = 2; cfg_rhold = 0; cfg_rdata = 32'hA5A5_0001; cfg_resp = 2'b01;
      req_ifu(32'h8000_0100); req_lsu_rd(32'h8000_0200);
      serve_all();
      cfg_rdata = 32'h5A5A_0002; cfg_resp = 2'b00;
      req_ifu(32'h8000_0104); req_lsu_rd(32'h8000_0204);
      serve_all();

      // LSU write, W valid two cycles ahead of AW
      lsu_wvalid = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
      #1;
      check("w_early_blocked", {lsu_wready, m_wvalid, busy}, 0);
      tick; tick;
      bv0 = bvalid_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
      req_lsu_wr(32'h0F00_0010, 32'h1234_5678, 4'hF);
      cfg_wgap = -1; cfg_lat = 2; cfg_resp = 2'b00;
      serve_all();
      check("wr_bvalid_cycles", bvalid_cnt - bv0, 1);
      check("wr_single_aw", aw_hs_cnt - aw0, 1);
      check("wr_single_w", w_hs_cnt - w0, 1);

      // IFU busy, LSU asks mid-transaction, IFU keeps requesting
      req_ifu(32'h3000_0040);
      tick;
      k = model_pick();
      check("mid_pick_ifu", k, 1);
      req_lsu_rd(32'h4000_0040);
      read_txn(0, 32'h3000_0040, 32'h0BAD_F00D, 2'b00, 2, 0);
      pend_ifu = 0;
      req_ifu(32'h3000_0044);
      cfg_lat = 1; cfg_rhold = 0; cfg_rdata = 32'h1111_2222; cfg_resp = 2'b10;
      serve_all();

      // IFU stalls R for 5 cycles with the LSU waiting
      req_ifu(32'h3000_0080);
      tick;
      k = model_pick();
      check("stall_pick_ifu", k, 1);
      req_lsu_rd(32'h4000_0080);
      read_txn(0, 32'h3000_0080, 32'hCAFE_0005, 2'b00, 1, 5);
      pend_ifu = 0;
      cfg_lat = 1; cfg_rhold = 0;
      serve_all();

      // downstream response while idle is ignored
      m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF; m_rresp = 2'b11; m_bvalid = 1'b1; m_bresp = 2'b11;
      #1;
      check("idle_resp_ignored", {ifu_rvalid, lsu_rvalid, lsu_bvalid, ifu_rdata, lsu_rdata, lsu_bresp}, 0);
      tick;
      check("idle_resp_no_grant", busy, 0);
      m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_bvalid = 1'b0; m_bresp = '0;

      // reset pulse in the middle of a write
      lsu_wvalid = 1'b1; lsu_wdata = 32'h7777_0000; lsu_wstrb = 4'h3;
      req_lsu_wr(32'h0F00_0020, 32'h7777_0000, 4'h3);
      tick;
      k = model_pick();
      check("rst_pick_write", k, 3);
      #1;
      check("rst_in_write", {busy, m_awvalid}, 2'b11);
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
      reset_n = 1'b0;
      #1;
      check("rst_outputs_now", any_out, 0);
      ref_last_lsu = 1'b0;
      pend_lw = 0;
      lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
      tick;
      reset_n = 1'b1;
      tick;
      #1;
      check("rst_release_idle", any_out, 0);
      cfg_lat = 1; cfg_rhold = 0; cfg_rdata = 32'h0101_0101; cfg_resp = 2'b00;
      req_ifu(32'h3000_00C0); req_lsu_rd(32'h4000_00C0);
      serve_all();

      // randomized mixes of requests
      cfg_rand = 1;
      for (int it = 0; it < 24; it++) begin
         a = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 1) req_ifu(a);
         case ($urandom_range(0, 3))
            1: req_lsu_rd(a ^ 32'h0001_0000);
            2: req_lsu_wr(a ^ 32'h0002_0000, $urandom, 4'($urandom_range(1, 15)));
            3: begin
               req_lsu_rd(a ^ 32'h0001_0000);
               req_lsu_wr(a ^ 32'h0002_0000, $urandom, 4'($urandom_range(1, 15)));
            end
            default: ;
         endcase
         serve_all();
         tick;
         #1;
         check("rand_idle", busy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
